// File: rtl/nor_netlist_evaluator_pkg.sv
// Shared types and sizing for the NOR netlist evaluator.
// Netlist dimensions are fixed here; all other files derive from them.
package nor_eval_pkg;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_IN      = 3;
  localparam int MAX_GATES = 16;
  localparam int NODES     = N_IN + MAX_GATES;
  localparam int NODE_W    = idx_w(NODES);
  localparam int GATE_W    = idx_w(MAX_GATES);
  localparam int CNT_W     = GATE_W + 1;
  localparam int TT_W      = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
`ifdef NOR_EVAL_SWEEP_EN
    ,
    SWEEP
`endif
  } state_t;

  typedef struct packed {
    logic [NODE_W-1:0] a;
    logic [NODE_W-1:0] b;
  } gate_t;

endpackage

// File: rtl/nor_netlist_evaluator_if.sv
// Input-vector / result handshake bundle.
// master drives vectors and consumes results; slave is the evaluator.
interface nor_netlist_evaluator_if;
  import nor_eval_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_bit
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_bit
  );
endinterface

// File: rtl/nor_netlist_evaluator_gate_table.sv
// Gate descriptor register file with operand validity check.
// An operand is usable only if it names a node already computed.
module nor_gate_table
  import nor_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [GATE_W-1:0] waddr,
  input  gate_t             wdata,
  input  logic [GATE_W-1:0] raddr,
  output logic [NODE_W-1:0] rd_a,
  output logic [NODE_W-1:0] rd_b,
  output logic              a_ok,
  output logic              b_ok
);
  localparam int LIM_W = NODE_W + 1;

  gate_t            tbl [MAX_GATES];
  logic [LIM_W-1:0] lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_GATES; i++)
        tbl[i] <= '0;
    end else if (we) begin
      tbl[waddr] <= wdata;
    end
  end

  assign rd_a = tbl[raddr].a;
  assign rd_b = tbl[raddr].b;

  // gate g may only read primary inputs and gates 0..g-1
  assign lim  = LIM_W'(N_IN) + LIM_W'(raddr);
  assign a_ok = {1'b0, rd_a} < lim;
  assign b_ok = {1'b0, rd_b} < lim;
endmodule

// File: rtl/nor_netlist_evaluator.sv
// Sequential NOR-netlist evaluator, one gate per cycle.
// Define NOR_EVAL_SWEEP_EN to add the truth-table sweep engine.
module nor_netlist_evaluator
  import nor_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [GATE_W-1:0] cfg_addr,
  input  logic [NODE_W-1:0] cfg_a,
  input  logic [NODE_W-1:0] cfg_b,
  input  logic              cfg_len_we,
  input  logic [CNT_W-1:0]  cfg_len,
  nor_netlist_evaluator_if.slave io,
  output logic              cfg_err,
  output logic              busy,
  input  logic              sweep_start,
  output logic              sweep_done,
  output logic [TT_W-1:0]   truth_table
);
  state_t            state;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  g;
  logic [CNT_W-1:0]  sat_len;
  logic [NODES-1:0]  node;
  logic [NODE_W-1:0] rd_a;
  logic [NODE_W-1:0] rd_b;
  logic [NODE_W-1:0] widx;
  logic              a_ok;
  logic              b_ok;
  logic              gval;
  logic              bad;
  logic              last;
  logic              idle;
  gate_t             wr_gate;

  assign idle        = (state == IDLE);
  assign io.in_ready = idle;
  assign busy        = !idle;
  assign wr_gate     = '{a: cfg_a, b: cfg_b};

  nor_gate_table u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && idle),
    .waddr (cfg_addr),
    .wdata (wr_gate),
    .raddr (g[GATE_W-1:0]),
    .rd_a  (rd_a),
    .rd_b  (rd_b),
    .a_ok  (a_ok),
    .b_ok  (b_ok)
  );

  assign sat_len = (cfg_len > CNT_W'(MAX_GATES)) ?
                   CNT_W'(MAX_GATES) : cfg_len;
  // invalid operands read as constant 0
  assign gval = !((a_ok && node[rd_a]) || (b_ok && node[rd_b]));
  assign bad  = !a_ok || !b_ok;
  assign widx = NODE_W'(N_IN) + NODE_W'(g[GATE_W-1:0]);
  assign last = (g + CNT_W'(1)) == len;

`ifdef NOR_EVAL_SWEEP_EN
  logic [N_IN-1:0] k;
  logic            ld;
  logic            res;
`else
  logic sweep_unused;
  assign sweep_unused = sweep_start;
  assign sweep_done   = 1'b0;
  assign truth_table  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      g            <= '0;
      node         <= '0;
      io.out_valid <= 1'b0;
      io.out_bit   <= 1'b0;
      cfg_err      <= 1'b0;
`ifdef NOR_EVAL_SWEEP_EN
      k            <= '0;
      ld           <= 1'b0;
      res          <= 1'b0;
      sweep_done   <= 1'b0;
      truth_table  <= '0;
`endif
    end else begin
`ifdef NOR_EVAL_SWEEP_EN
      sweep_done <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (cfg_len_we)
            len <= sat_len;
          if (io.in_valid) begin
            node[N_IN-1:0] <= io.in_vec;
            g              <= '0;
            if (len == '0) begin
              io.out_bit   <= 1'b0;
              io.out_valid <= 1'b1;
              state        <= RESP;
            end else begin
              state <= EVAL;
            end
          end
`ifdef NOR_EVAL_SWEEP_EN
          else if (sweep_start) begin
            k     <= '0;
            ld    <= 1'b1;
            state <= SWEEP;
          end
`endif
        end
        EVAL: begin
          node[widx] <= gval;
          g          <= g + CNT_W'(1);
          if (bad)
            cfg_err <= 1'b1;
          if (last) begin
            io.out_bit   <= gval;
            io.out_valid <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            state        <= IDLE;
          end
        end
`ifdef NOR_EVAL_SWEEP_EN
        // per k: load, len gate cycles, store
        SWEEP: begin
          if (ld) begin
            node[N_IN-1:0] <= k;
            g              <= '0;
            res            <= 1'b0;
            ld             <= 1'b0;
          end else if (g == len) begin
            truth_table[k] <= res;
            if (&k) begin
              sweep_done <= 1'b1;
              state      <= IDLE;
            end else begin
              k  <= k + N_IN'(1);
              ld <= 1'b1;
            end
          end else begin
            node[widx] <= gval;
            res        <= gval;
            g          <= g + CNT_W'(1);
            if (bad)
              cfg_err <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nor_netlist_evaluator.sv
// Randomised scoreboard bench for nor_netlist_evaluator.
// Reference model evaluates the netlist directly from node rules.
module tb_nor_netlist_evaluator;
  import nor_eval_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [GATE_W-1:0] cfg_addr = '0;
  logic [NODE_W-1:0] cfg_a = '0;
  logic [NODE_W-1:0] cfg_b = '0;
  logic              cfg_len_we = 1'b0;
  logic [CNT_W-1:0]  cfg_len = '0;
  logic              cfg_err;
  logic              busy;
  logic              sweep_start = 1'b0;
  logic              sweep_done;
  logic [TT_W-1:0]   truth_table;

  nor_netlist_evaluator_if io();

  nor_netlist_evaluator dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_a       (cfg_a),
    .cfg_b       (cfg_b),
    .cfg_len_we  (cfg_len_we),
    .cfg_len     (cfg_len),
    .io          (io),
    .cfg_err     (cfg_err),
    .busy        (busy),
    .sweep_start (sweep_start),
    .sweep_done  (sweep_done),
    .truth_table (truth_table)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // reference model
  int m_a [MAX_GATES];
  int m_b [MAX_GATES];
  int m_len = 0;
  bit m_err = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < MAX_GATES; i++) begin
      m_a[i] = 0;
      m_b[i] = 0;
    end
    m_len = 0;
    m_err = 1'b0;
  endfunction

  function automatic bit model_eval(input int vec);
    bit v [NODES];
    bit r;
    r = 1'b0;
    for (int i = 0; i < NODES; i++) v[i] = 1'b0;
    for (int i = 0; i < N_IN; i++) v[i] = bit'((vec >> i) & 1);
    for (int g = 0; g < m_len; g++) begin
      int lim = N_IN + g;
      bit x;
      bit y;
      if (m_a[g] >= lim || m_b[g] >= lim) m_err = 1'b1;
      x = (m_a[g] < lim) ? v[m_a[g]] : 1'b0;
      y = (m_b[g] < lim) ? v[m_b[g]] : 1'b0;
      v[N_IN + g] = ~(x | y);
      r = v[N_IN + g];
    end
    return r;
  endfunction

  typedef struct {
    bit val;
    bit err;
    int acc;
    int lat;
  } exp_t;

  exp_t sbq [$];
  bit   force_low = 1'b0;
  int   done_cnt = 0;

  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      io.out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor
  bit seen = 1'b0;
  int seen_cyc = 0;
  bit held_bit = 1'b0;
  bit ready_next = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (sweep_done) done_cnt++;
    if (ready_next) begin
      ready_next = 1'b0;
      if (!rst) check("in_ready_after_resp", io.in_ready, 1);
    end
    if (!rst && io.out_valid) begin
      check("in_ready_low_in_resp", io.in_ready, 0);
      if (!seen) begin
        seen     = 1'b1;
        seen_cyc = cyc;
        held_bit = io.out_bit;
      end else begin
        check("out_bit_stable", io.out_bit, held_bit);
      end
      if (io.out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          check("out_bit", io.out_bit, e.val);
          check("latency", seen_cyc + 1 - e.acc, e.lat);
          check("cfg_err", cfg_err, e.err);
        end
        seen       = 1'b0;
        ready_next = 1'b1;
      end
    end
  end

  task automatic send(input int vec);
    exp_t e;
    int   t;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_vec   = N_IN'(vec);
    t = 0;
    while (!io.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!io.in_ready) begin
      check("accept_timeout", io.in_ready, 1);
      io.in_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    e.lat = m_len + 1;
    e.val = model_eval(vec);
    e.err = m_err;
    sbq.push_back(e);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sbq.size() != 0 || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("idle_timeout", sbq.size(), 0);
  endtask

  task automatic cfg_gate(input int g, input int a, input int b);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = GATE_W'(g);
    cfg_a    = NODE_W'(a);
    cfg_b    = NODE_W'(b);
    @(negedge clk);
    cfg_we   = 1'b0;
    m_a[g] = a;
    m_b[g] = b;
  endtask

  task automatic set_len(input int n);
    @(negedge clk);
    cfg_len_we = 1'b1;
    cfg_len    = CNT_W'(n);
    @(negedge clk);
    cfg_len_we = 1'b0;
    m_len = (n > MAX_GATES) ? MAX_GATES : n;
  endtask

  task automatic load_x42();
    set_len(8);
    cfg_gate(0, 0, 0);
    cfg_gate(1, 2, 2);
    cfg_gate(2, 3, 1);
    cfg_gate(3, 0, 4);
    cfg_gate(4, 5, 6);
    cfg_gate(5, 1, 2);
    cfg_gate(6, 1, 8);
    cfg_gate(7, 9, 7);
  endtask

  task automatic load_random(input int n, input bit allow_bad);
    set_len(n);
    for (int g = 0; g < MAX_GATES; g++) begin
      int a = $urandom_range(0, N_IN + g - 1);
      int b = $urandom_range(0, N_IN + g - 1);
      if (allow_bad && $urandom_range(0, 9) == 0)
        a = $urandom_range(0, (1 << NODE_W) - 1);
      cfg_gate(g, a, b);
    end
  endtask

  initial begin
    int s_cyc;
    int t;
    int tt;
    int d0;
    exp_t e;
    io.in_valid = 1'b0;
    io.in_vec   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_truth_table", truth_table, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", io.in_ready, 1);

    // single NOT gate
    set_len(1);
    cfg_gate(0, 0, 0);
    send(0);
    send(1);
    wait_idle();

    // 0x42 netlist, all vectors
    load_x42();
    for (int i = 0; i < 8; i++) send((i * 5) % 8);
    wait_idle();

    // backpressure
    force_low = 1'b1;
    send(1);
    t = 0;
    while (!io.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid", io.out_valid, 1);
    repeat (5) @(negedge clk);
    force_low = 1'b0;
    wait_idle();

    // empty netlist
    set_len(0);
    send($urandom_range(0, 7));
    wait_idle();

    // forward reference
    set_len(2);
    cfg_gate(0, 0, 1);
    cfg_gate(1, 5, 2);
    send(3);
    wait_idle();
    set_len(1);
    send(2);
    wait_idle();
    check("cfg_err_sticky", cfg_err, 1);

    // reset mid-evaluation
    load_random(16, 1'b0);
    send($urandom_range(0, 7));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", io.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    sbq.delete();
    seen = 1'b0;
    model_reset();
    send($urandom_range(0, 7));
    wait_idle();

    // configuration writes ignored while evaluating
    load_x42();
    send(6);
    cfg_we     = 1'b1;
    cfg_addr   = GATE_W'(7);
    cfg_a      = '0;
    cfg_b      = '0;
    cfg_len_we = 1'b1;
    cfg_len    = CNT_W'(1);
    repeat (3) @(negedge clk);
    cfg_we     = 1'b0;
    cfg_len_we = 1'b0;
    wait_idle();
    send(6);
    send(1);
    wait_idle();

    // truth-table sweep
    @(negedge clk);
    sweep_start = 1'b1;
    s_cyc = cyc + 1;
    d0 = done_cnt;
    @(negedge clk);
    sweep_start = 1'b0;
    tt = 0;
`ifdef NOR_EVAL_SWEEP_EN
    check("sweep_in_ready_low", io.in_ready, 0);
    for (int k = 0; k < TT_W; k++) tt |= int'(model_eval(k)) << k;
    t = 0;
    while (!sweep_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("sweep_done_seen", sweep_done, 1);
    check("sweep_latency", cyc - s_cyc, TT_W * (m_len + 2));
    check("sweep_truth_table", truth_table, tt);
    @(negedge clk);
    check("sweep_idle", busy, 0);
`else
    repeat (20) @(negedge clk);
    check("nosweep_busy", busy, 0);
    check("nosweep_done", done_cnt - d0, 0);
    check("nosweep_tt", truth_table, 0);
`endif

    // in_valid wins over sweep_start
    d0 = done_cnt;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_vec   = N_IN'(6);
    sweep_start = 1'b1;
    check("tie_in_ready", io.in_ready, 1);
    e.acc = cyc + 1;
    e.lat = m_len + 1;
    e.val = model_eval(6);
    e.err = m_err;
    sbq.push_back(e);
    @(negedge clk);
    io.in_valid = 1'b0;
    sweep_start = 1'b0;
    wait_idle();
    repeat (100) @(negedge clk);
    check("tie_no_sweep", done_cnt - d0, 0);

    // random netlists, some with bad operands and over-long len
    for (int r = 0; r < 6; r++) begin
      load_random($urandom_range(0, 20), r >= 3);
      for (int i = 0; i < 10; i++) send($urandom_range(0, 7));
      wait_idle();
    end
    check("tt_holds", truth_table, tt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nor_netlist_evaluator.md
Name: nor_netlist_evaluator

Overview:
- Programmable evaluator for NOR-only logic netlists, the generalised form of the fixed 3-input NOR/NOT circuit blocks.
- The gate list is loaded at run time through a config port.
- Each input vector is evaluated sequentially, one gate per cycle, and the result is returned over a valid/ready handshake.
- Used by circuit-scoring benches to check candidate designs against target truth tables (e.g. 0x42).

Parameters:
N_IN, 3, number of primary inputs (1..6)
MAX_GATES, 16, gate-table depth
NODE_W, $clog2(N_IN+MAX_GATES), node index width
GATE_W, $clog2(MAX_GATES), gate address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  write gate descriptor (honoured in IDLE only)
cfg_addr  in  GATE_W  gate index
cfg_a  in  NODE_W  operand A node index
cfg_b  in  NODE_W  operand B node index
cfg_len_we  in  1  write gate count (IDLE only)
cfg_len  in  GATE_W+1  number of active gates, saturated to MAX_GATES
in_valid  in  1  input vector valid
in_ready  out  1  high in IDLE
in_vec  in  N_IN  primary input values
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_bit  out  1  netlist output
cfg_err  out  1  sticky: forward/self/out-of-range operand seen
busy  out  1  state != IDLE
sweep_start  in  1  start truth-table sweep pulse
sweep_done  out  1  one-cycle pulse at sweep end
truth_table  out  2**N_IN  bit k = f(k)

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset.
- Reset clears the gate table (a=b=0), len=0, node registers, out_valid, out_bit, cfg_err, sweep_done and truth_table. State returns to IDLE.
- Reset mid-evaluation or mid-sweep drops the transaction with no output.
- Node numbering:
  - nodes 0..N_IN-1 = in_vec bits.
  - node N_IN+g = output of gate g.
  - gate g = NOR(node[a], node[b]); a==b gives NOT.
- FSM states: IDLE, EVAL, RESP, SWEEP.
- IDLE:
  - in_valid && in_ready: latch in_vec into the input nodes, g=0, go to EVAL.
  - len==0: go straight to RESP with out_bit=0.
- EVAL:
  - Each cycle compute gate g and write node[N_IN+g]; g++.
  - After gate len-1, go to RESP. out_bit = last gate value.
  - out_valid rises exactly len+1 cycles after the accepting edge.
- RESP:
  - out_valid held with out_bit stable until out_ready.
  - Then go to IDLE. in_ready is high the next cycle, giving no back-to-back overlap.
- Bad operands: index >= N_IN+g (forward or self reference) or index out of range reads node value 0 and sets cfg_err.
- cfg_we / cfg_len_we outside IDLE: ignored, no error.
- Simultaneous in_valid and sweep_start in IDLE: evaluation accepted, sweep_start dropped.

Optional Feature:
NOR_EVAL_SWEEP_EN
- Defined:
  - sweep_start in IDLE enters SWEEP, which iterates k=0..2**N_IN-1.
  - Per k: one cycle loading nodes = k, then len gate cycles, then store truth_table[k] in the next cycle (len+2 cycles per k).
  - sweep_done pulses the cycle after the final store, then back to IDLE.
  - truth_table holds until the next sweep or reset. in_ready stays low during SWEEP.
- Undefined: sweep_start ignored; truth_table and sweep_done tied 0; no SWEEP state.

Decomposition:
- Package nor_eval_pkg:
  - state enum
  - gate descriptor struct {a, b}
  - function computing node/gate widths
- Sub-module nor_gate_table: register file, one write port and two combinational read ports, index-validity check.

Test Plan:
- NOT gate: len=1, gate0 a=b=0, in_vec=3'b000 -> out_valid 2 cycles after accept, out_bit=1; in_vec=3'b001 -> out_bit=0.
- Backpressure: 8-gate 0x42 netlist, in_vec=3'b001, out_ready low 5 cycles -> out_bit=1 held stable, in_ready low throughout; accept occurs in the cycle after out_ready.
- len=0 -> out_bit=0 one cycle after accept; gate1 with a=5 (forward reference, N_IN=3) -> cfg_err=1, sticky until reset.
- Sweep (macro on): 0x42 netlist, sweep_start -> sweep_done after 8*(8+2) cycles, truth_table=8'h42.
- Reset asserted mid-EVAL -> next cycle out_valid=0, busy=0, len=0, and a fresh evaluation returns 0.
- cfg_we during EVAL -> table unchanged; the re-evaluated result matches the prior result.
